// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module  : pc_unit_pkg
// Brief   : Shared CPU types: PC-unit FSM states, branch ops, exception causes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_VEC_REQ = 2'd1,
    ST_DONE    = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_GT = 2'b10,
    BR_LE = 2'b11
  } br_op_e;

  localparam logic [1:0] EXC_ALIGN  = 2'd0;
  localparam logic [1:0] EXC_OPCODE = 2'd1;
  localparam logic [1:0] EXC_OVF    = 2'd2;
  localparam logic [1:0] EXC_DIV0   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pc_unit_if.sv
// ============================================================================
// Module  : pc_unit_if
// Brief   : Control/vector bus between the CPU core and the PC register stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_unit_if;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic        vec_req;
  logic [31:0] vec_addr;
  logic        vec_valid;
  logic [7:0]  vec_data;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  exc_cause;
  logic        exc_busy;
  logic        exc_done;

  // Core / memory side
  modport master (
    output pc_next, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt,
           exc_req, exc_code, vec_valid, vec_data,
    input  vec_req, vec_addr, pc, epc, exc_cause, exc_busy, exc_done
  );

  // PC register stage side
  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt,
           exc_req, exc_code, vec_valid, vec_data,
    output vec_req, vec_addr, pc, epc, exc_cause, exc_busy, exc_done
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit_branch_cond.sv
// ============================================================================
// Module  : branch_cond
// Brief   : Combinational branch-taken evaluator from branch op and ALU flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
  import pc_unit_pkg::*;
(
  input  wire logic [1:0] branch_op_i,
  input  wire logic       alu_zero_i,
  input  wire logic       alu_gt_i,
  output logic            taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (branch_op_i)
      BR_EQ:   taken_o =  alu_zero_i;
      BR_NE:   taken_o = ~alu_zero_i;
      BR_GT:   taken_o =  alu_gt_i;
      BR_LE:   taken_o = ~alu_gt_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module  : pc_unit
// Brief   : PC/EPC register stage with exception vector fetch sequence.
//           Optional macro PC_ALIGN_CHECK_EN traps misaligned PC writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = 32'd252
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  pc_unit_if.slave   bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        w_taken;
  logic        w_write_en;
  logic        w_align_fault;

  branch_cond u_branch_cond (
    .branch_op_i (bus.branch_op),
    .alu_zero_i  (bus.alu_zero),
    .alu_gt_i    (bus.alu_gt),
    .taken_o     (w_taken)
  );

  assign w_write_en = bus.pc_write | (bus.pc_write_cond & w_taken);

`ifdef PC_ALIGN_CHECK_EN
  assign w_align_fault = w_write_en & (bus.pc_next[1:0] != 2'b00);
`else
  assign w_align_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        // Exceptions take priority over any PC write in the same cycle.
        if (bus.exc_req) begin
          epc_d   = pc_q - 32'd4;
          cause_d = bus.exc_code;
          state_d = ST_VEC_REQ;
        end else if (w_align_fault) begin
          epc_d   = pc_q - 32'd4;
          cause_d = EXC_ALIGN;
          state_d = ST_VEC_REQ;
        end else if (w_write_en) begin
          pc_d = bus.pc_next;
        end
      end
      ST_VEC_REQ: begin
        if (bus.vec_valid) begin
          pc_d    = {24'b0, bus.vec_data};
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.vec_req   = (state_q == ST_VEC_REQ);
  assign bus.vec_addr  = (state_q == ST_VEC_REQ) ? (VEC_BASE + {30'b0, cause_q}) : 32'd0;
  assign bus.exc_busy  = (state_q != ST_RUN);
  assign bus.exc_done  = (state_q == ST_DONE);
  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.exc_cause = cause_q;

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program-counter register stage that sits directly downstream of the PC-source multiplexer and owns the architectural `pc` and `epc` registers. Each cycle it decides whether to load the multiplexer output, based on an unconditional write, a conditional branch write, or an exception sequence. On an exception it captures the faulting address into EPC and fetches the handler address byte from the exception vector table in memory. It then loads that address into PC, all before handing control back to the main control FSM.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `VEC_BASE`, 32'd252: byte address of vector-table entry for cause 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `pc_next`  in  32  candidate next PC from the PC-source multiplexer.
- `pc_write`  in  1  unconditional PC load request.
- `pc_write_cond`  in  1  branch PC load request, qualified by `branch_op`.
- `branch_op`  in  2  branch condition select:
  - 00: beq, taken on `alu_zero`
  - 01: bne, taken on !`alu_zero`
  - 10: bgt, taken on `alu_gt`
  - 11: ble, taken on !`alu_gt`
- `alu_zero`, `alu_gt`  in  1 each  ALU flags.
- `exc_req`  in  1  exception request, single-cycle sample.
- `exc_code`  in  2  exception cause:
  - 1: invalid opcode
  - 2: overflow
  - 3: divide by zero
  - 0: misalignment
- `vec_req`  out  1  vector-table read request.
- `vec_addr`  out  32  vector-table byte address.
- `vec_valid`  in  1  vector byte valid.
- `vec_data`  in  8  handler address byte.
- `pc`  out  32  current PC.
- `epc`  out  32  exception PC.
- `exc_cause`  out  2  latched cause.
- `exc_busy`  out  1  exception sequence in progress.
- `exc_done`  out  1  one-cycle completion pulse.

## Operation
- Reset values:
  - `pc`=`RESET_PC`
  - `epc`=0, `exc_cause`=0
  - `vec_req`=0, `vec_addr`=0
  - `exc_busy`=0, `exc_done`=0
  - FSM=RUN
- FSM states: RUN, VEC_REQ, DONE.
- RUN:
  - write_en = `pc_write` | (`pc_write_cond` & cond(`branch_op`)).
  - If write_en, `pc`<=`pc_next`.
- RUN with `exc_req`=1:
  - `epc`<=`pc`-4, computed modulo 2^32 (so `pc`=0 gives 32'hFFFF_FFFC).
  - `exc_cause`<=`exc_code`.
  - `pc` is NOT updated, even if write_en=1 in the same cycle; the exception has priority.
  - Next state VEC_REQ.
- VEC_REQ:
  - `vec_req`=1, `vec_addr`=`VEC_BASE`+`exc_cause`.
  - All write requests are ignored.
  - On an edge with `vec_valid`=1: `pc`<={24'b0,`vec_data`}, next state DONE.
  - With `vec_valid`=0 the FSM stays in VEC_REQ indefinitely.
- DONE:
  - `exc_done`=1 for exactly one cycle.
  - Writes are still ignored.
  - Next state RUN.
- `exc_busy`=1 in VEC_REQ and DONE.
- `exc_req` asserted while `exc_busy`=1 is dropped. It is not queued, and EPC is not overwritten.
- `reset_n`=0 in any state restores all reset values at the next edge and abandons an in-flight vector read.

## Timing
- PC load latency: 1 edge. `pc` reflects `pc_next` in the cycle after write_en.
- `vec_req`, `vec_addr`, `exc_busy` and `exc_done` are registered state decodes, with no combinational path from inputs.
- Exception latency:
  - Edge 1 captures EPC.
  - Earliest edge 2 loads the handler (when `vec_valid` is already 1 in the first VEC_REQ cycle).
  - `exc_done` is high in the cycle after the handler load.
- `vec_valid` is sampled only in VEC_REQ; any value in other states is ignored.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - In RUN, if write_en=1 and `pc_next`[1:0]≠0, the PC write is suppressed.
  - An internal exception is raised: `epc`<=`pc`-4, `exc_cause`<=0, then VEC_REQ.
  - External `exc_req` in the same cycle wins with its own code.
- `PC_ALIGN_CHECK_EN` undefined:
  - No check; misaligned values are loaded verbatim.
  - Cause 0 occurs only via external `exc_code`=0.

## Structure
- Shared CPU package contents:
  - FSM state enum.
  - `branch_op` encodings (BR_EQ, BR_NE, BR_GT, BR_LE).
  - Exception cause codes (EXC_ALIGN=0, EXC_OPCODE=1, EXC_OVF=2, EXC_DIV0=3).
- One natural sub-module: `branch_cond`, the combinational condition evaluator from `branch_op`/flags to taken.

## Test plan
- Reset, then `pc_write`=1 with `pc_next`=32'h0000_0010 → `pc`=0x10 one cycle later. With `pc_write`=0, `pc` holds.
- `pc_write_cond`=1 with `branch_op`=01 and `alu_zero`=1 → no load. With `alu_zero`=0 → `pc`=`pc_next`. Repeat for all four ops, taken and not taken.
- `pc`=0x40, `exc_req`=1, `exc_code`=2, `pc_write`=1 in the same cycle:
  - `epc`=0x3C, `pc` stays 0x40.
  - `vec_addr`=254.
  - `vec_valid` held off 3 cycles, then `vec_data`=8'h80 → `pc`=0x80, `exc_done` pulses once.
- Second `exc_req` during VEC_REQ → `epc` and `exc_cause` unchanged. `pc`=0 with `exc_req` → `epc`=32'hFFFF_FFFC.
- `reset_n`=0 during VEC_REQ → next cycle `pc`=`RESET_PC`, `vec_req`=0, `exc_busy`=0.
- `PC_ALIGN_CHECK_EN` on, `pc_write` with `pc_next`=0x22 → `pc` unchanged, `exc_cause`=0, `vec_addr`=252. With the macro off, `pc`=0x22.
